// File: rtl/axis_spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axis_spi_pkg
// Purpose  : Shared types and width helpers for the SPI frame sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package axis_spi_pkg;

  // Frame sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } frame_state_t;

  // Slave address width: at least one bit even for a single chip-select
  function automatic int calc_addr_w(input int slave_num);
    return (slave_num > 1) ? $clog2(slave_num) : 1;
  endfunction

  // Length field width: holds frame length minus one
  function automatic int calc_len_w(input int max_len);
    return $clog2(max_len);
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_if.sv
`default_nettype none
// ============================================================================
// Module   : axis_if
// Purpose  : Minimal AXI-Stream bundle (tdata/tvalid/tready/tlast).
// Revision : 1.0 - initial release
// ============================================================================
interface axis_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/axis_spi_beat_cnt.sv
`default_nettype none
// ============================================================================
// Module   : axis_spi_beat_cnt
// Purpose  : Clearable beat counter that saturates at len and flags
//            when the current beat is the last one of the frame.
// Revision : 1.0 - initial release
// ============================================================================
module axis_spi_beat_cnt #(
  parameter int LEN_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             last_o
);

  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] cnt_d;

  // Next count: clear wins, increment stops at len so it can never wrap
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !last_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == len_i);

endmodule
`default_nettype wire

// File: rtl/axis_spi_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : axis_spi_frame_ctrl
// Purpose  : Frame sequencer in front of an AXI-Stream SPI master. Streams
//            len+1 TX bytes with tlast on the final one, holds the slave
//            address for the frame, and re-frames the returned RX bytes.
//            Optional fill frames enabled by AXIS_SPI_FRAME_FILL_EN.
// Revision : 1.0 - initial release
// ============================================================================
module axis_spi_frame_ctrl
  import axis_spi_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    SLAVE_NUM  = 2,
  parameter int                    MAX_LEN    = 256,
  parameter logic [DATA_WIDTH-1:0] FILL_BYTE  = 8'hFF
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 req_valid_i,
  output logic                                 req_ready_o,
  input  logic [calc_addr_w(SLAVE_NUM)-1:0]    req_addr_i,
  input  logic [calc_len_w(MAX_LEN)-1:0]       req_len_i,
  input  logic                                 req_fill_i,
  axis_if.slave                                s_tx,
  axis_if.master                               m_spi,
  output logic [calc_addr_w(SLAVE_NUM)-1:0]    spi_addr_o,
  axis_if.slave                                s_spi,
  axis_if.master                               m_rx,
  output logic                                 busy_o,
  output logic                                 done_o,
  output logic                                 err_o
);

  localparam int ADDR_W = calc_addr_w(SLAVE_NUM);
  localparam int LEN_W  = calc_len_w(MAX_LEN);

  frame_state_t          state_q;
  frame_state_t          state_d;
  logic [ADDR_W-1:0]     addr_q;
  logic [LEN_W-1:0]      len_q;
  logic                  done_q;
  logic                  err_q;

  logic                  fill_w;
  logic [DATA_WIDTH-1:0] tx_data_w;
  logic                  req_hs_w;
  logic                  tx_hs_w;
  logic                  rx_hs_w;
  logic                  tx_last_w;
  logic                  rx_last_w;
  logic                  unused_tlast_w;

  // User TX tlast carries no meaning here; frame boundaries come from len
  assign unused_tlast_w = s_tx.tlast;

`ifdef AXIS_SPI_FRAME_FILL_EN
  logic fill_q;

  // Fill mode latched with the request and held for the frame
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fill_q <= 1'b0;
    end else if (req_hs_w) begin
      fill_q <= req_fill_i;
    end
  end

  assign fill_w    = fill_q;
  assign tx_data_w = fill_q ? FILL_BYTE : s_tx.tdata;
`else
  logic unused_fill_w;
  assign unused_fill_w = req_fill_i;
  assign fill_w        = 1'b0;
  assign tx_data_w     = s_tx.tdata;
`endif

  // Handshakes derived from inputs only, so the output mux stays acyclic
  assign req_hs_w = (state_q == IDLE) && req_valid_i;
  assign tx_hs_w  = (state_q == RUN) && (fill_w || s_tx.tvalid) && m_spi.tready;
  assign rx_hs_w  = (state_q != IDLE) && s_spi.tvalid && m_rx.tready;

  axis_spi_beat_cnt #(.LEN_W(LEN_W)) u_tx_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (req_hs_w),
    .inc_i  (tx_hs_w),
    .len_i  (len_q),
    .last_o (tx_last_w)
  );

  axis_spi_beat_cnt #(.LEN_W(LEN_W)) u_rx_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (req_hs_w),
    .inc_i  (rx_hs_w),
    .len_i  (len_q),
    .last_o (rx_last_w)
  );

  // Next state and stream steering; RX completion takes priority over TX
  always_comb begin
    state_d      = state_q;
    req_ready_o  = 1'b0;
    m_spi.tvalid = 1'b0;
    m_spi.tdata  = tx_data_w;
    m_spi.tlast  = 1'b0;
    s_tx.tready  = 1'b0;
    m_rx.tvalid  = 1'b0;
    m_rx.tdata   = s_spi.tdata;
    m_rx.tlast   = 1'b0;
    s_spi.tready = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready_o  = 1'b1;
        s_spi.tready = 1'b1;
        if (req_valid_i) state_d = RUN;
      end
      RUN: begin
        m_spi.tvalid = fill_w | s_tx.tvalid;
        m_spi.tlast  = tx_last_w;
        s_tx.tready  = ~fill_w & m_spi.tready;
        m_rx.tvalid  = s_spi.tvalid;
        m_rx.tlast   = rx_last_w;
        s_spi.tready = m_rx.tready;
        if (rx_hs_w && rx_last_w) begin
          state_d = IDLE;
        end else if (tx_hs_w && tx_last_w) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        m_rx.tvalid  = s_spi.tvalid;
        m_rx.tlast   = rx_last_w;
        s_spi.tready = m_rx.tready;
        if (rx_hs_w && rx_last_w) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, frame latches and registered status pulses
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (req_hs_w) begin
        addr_q <= req_addr_i;
        len_q  <= req_len_i;
      end
      done_q <= rx_hs_w && rx_last_w;
      err_q  <= rx_hs_w && (s_spi.tlast != rx_last_w);
    end
  end

  assign spi_addr_o = addr_q;
  assign busy_o     = (state_q != IDLE);
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_spi_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_spi_frame_ctrl
// Purpose  : Randomized scoreboard bench for axis_spi_frame_ctrl with a
//            behavioural SPI-master/slave model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_spi_frame_ctrl;

  localparam int DW = 8;
  localparam int AW = 1;
  localparam int LW = 8;

`ifdef AXIS_SPI_FRAME_FILL_EN
  localparam bit FILL_EN = 1'b1;
`else
  localparam bit FILL_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [LW-1:0] req_len;
  logic          req_fill;
  logic [AW-1:0] spi_addr;
  logic          busy, done, err;

  axis_if #(.DATA_WIDTH(DW)) tx_if ();
  axis_if #(.DATA_WIDTH(DW)) spi_tx_if ();
  axis_if #(.DATA_WIDTH(DW)) spi_rx_if ();
  axis_if #(.DATA_WIDTH(DW)) rx_if ();

  axis_spi_frame_ctrl #(
    .DATA_WIDTH (DW),
    .SLAVE_NUM  (2),
    .MAX_LEN    (256),
    .FILL_BYTE  (8'hFF)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .req_len_i   (req_len),
    .req_fill_i  (req_fill),
    .s_tx        (tx_if),
    .m_spi       (spi_tx_if),
    .spi_addr_o  (spi_addr),
    .s_spi       (spi_rx_if),
    .m_rx        (rx_if),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [7:0] d; logic last; } beat_t;
  typedef struct packed { logic [7:0] d; logic tl; logic inj; } pend_t;

  beat_t      exp_tx[$];
  beat_t      exp_rx[$];
  logic [7:0] tx_src[$];
  pend_t      pend[$];

  int checks = 0;
  int errors = 0;

  int cur_len, cur_addr, inj_idx, tx_frame_cnt;
  bit cur_fill, cur_fixed;
  bit tx_taken, rx_taken, exp_done_next, exp_err_next;
  int done_cnt = 0, err_cnt = 0, exp_done_total = 0, exp_err_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Stimulus drivers: upstream TX source, SPI master return path, sink ready
  always @(posedge clk) begin
    #1;
    if (rst) begin
      tx_if.tvalid     = 1'b0;
      tx_if.tdata      = '0;
      tx_if.tlast      = 1'b0;
      spi_rx_if.tvalid = 1'b0;
      spi_rx_if.tdata  = '0;
      spi_rx_if.tlast  = 1'b0;
      rx_if.tready     = 1'b0;
      spi_tx_if.tready = 1'b0;
    end else begin
      if (!(tx_if.tvalid && !tx_taken)) begin
        if (tx_src.size() > 0 && $urandom_range(0, 9) < 7) begin
          tx_if.tvalid = 1'b1;
          tx_if.tdata  = tx_src[0];
        end else begin
          tx_if.tvalid = 1'b0;
        end
      end
      tx_taken = 1'b0;
      if (!(spi_rx_if.tvalid && !rx_taken)) begin
        if (pend.size() > 0 && $urandom_range(0, 9) < 6) begin
          spi_rx_if.tvalid = 1'b1;
          spi_rx_if.tdata  = pend[0].d;
          spi_rx_if.tlast  = pend[0].tl;
        end else begin
          spi_rx_if.tvalid = 1'b0;
        end
      end
      rx_taken = 1'b0;
      rx_if.tready     = ($urandom_range(0, 9) < 7);
      spi_tx_if.tready = ($urandom_range(0, 9) < 8);
    end
  end

  // Monitor / scoreboard, sampled mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      exp_tx.delete(); exp_rx.delete(); tx_src.delete(); pend.delete();
      tx_taken = 0; rx_taken = 0; exp_done_next = 0; exp_err_next = 0;
    end else begin
      if (done || exp_done_next) begin
        chk("done_pulse", done, exp_done_next);
        if (done) chk("busy_at_done", busy, 0);
      end
      if (done) done_cnt++;
      if (err || exp_err_next) chk("err_pulse", err, exp_err_next);
      if (err) err_cnt++;
      exp_done_next = 0;
      exp_err_next  = 0;

      if (tx_if.tvalid && tx_if.tready) begin
        if (tx_src.size() > 0) void'(tx_src.pop_front());
        tx_taken = 1;
      end

      if (spi_rx_if.tvalid && spi_rx_if.tready) begin
        if (pend.size() > 0) begin
          if (busy) exp_err_next = pend[0].inj;
          void'(pend.pop_front());
        end
        rx_taken = 1;
      end

      if (rx_if.tvalid && rx_if.tready) begin
        if (exp_rx.size() == 0) begin
          chk("rx_unexpected", 1, 0);
        end else begin
          beat_t b;
          b = exp_rx.pop_front();
          chk("rx_data", rx_if.tdata, b.d);
          chk("rx_tlast", rx_if.tlast, b.last);
          chk("rx_addr", spi_addr, cur_addr);
          if (b.last) exp_done_next = 1;
        end
      end

      if (spi_tx_if.tvalid && spi_tx_if.tready) begin
        if (exp_tx.size() == 0) begin
          chk("tx_unexpected", 1, 0);
        end else begin
          beat_t b;
          pend_t p;
          logic [7:0] rd;
          b = exp_tx.pop_front();
          chk("tx_data", spi_tx_if.tdata, b.d);
          chk("tx_tlast", spi_tx_if.tlast, b.last);
          chk("tx_addr", spi_addr, cur_addr);
          if (cur_fill) chk("fill_s_tx_ready", tx_if.tready, 0);
          rd    = cur_fixed ? 8'h3C : 8'($urandom);
          p.d   = rd;
          p.inj = (tx_frame_cnt == inj_idx);
          p.tl  = (tx_frame_cnt == cur_len) ^ p.inj;
          pend.push_back(p);
          exp_rx.push_back('{d: rd, last: (tx_frame_cnt == cur_len)});
        end
        tx_frame_cnt++;
      end
    end
  end

  task automatic start_frame(input int len, input int addr, input bit fill,
                             input int inj, input bit fixed);
    int guard = 0;
    while (busy && guard < 1000) begin
      @(posedge clk); #2;
      guard++;
    end
    if (busy) chk("idle_timeout", 1, 0);
    cur_len      = len;
    cur_addr     = addr;
    cur_fill     = fill && FILL_EN;
    inj_idx      = inj;
    cur_fixed    = fixed;
    tx_frame_cnt = 0;
    for (int i = 0; i <= len; i++) begin
      logic [7:0] d;
      d = cur_fill ? 8'hFF : (fixed ? 8'hA5 : 8'($urandom));
      exp_tx.push_back('{d: d, last: (i == len)});
      if (!cur_fill) tx_src.push_back(d);
    end
    if (inj >= 0 && inj <= len) exp_err_total++;
    req_valid = 1'b1;
    req_addr  = AW'(addr);
    req_len   = LW'(len);
    req_fill  = fill;
    @(posedge clk); #2;
    req_valid = 1'b0;
    chk("busy_after_req", busy, 1);
  endtask

  task automatic wait_done();
    int guard = 0;
    exp_done_total++;
    while (done_cnt < exp_done_total && guard < 20000) begin
      @(posedge clk); #2;
      guard++;
    end
    if (done_cnt < exp_done_total) chk("done_timeout", 1, 0);
    chk("err_count", err_cnt, exp_err_total);
    chk("addr_hold_idle", spi_addr, cur_addr);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_len = '0; req_fill = 1'b0;
    inj_idx = -1; cur_len = 0; cur_addr = 0; cur_fill = 0; cur_fixed = 0; tx_frame_cnt = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_m_spi_tvalid", spi_tx_if.tvalid, 0);
    chk("rst_m_rx_tvalid", rx_if.tvalid, 0);
    chk("rst_m_spi_tlast", spi_tx_if.tlast, 0);
    chk("rst_m_rx_tlast", rx_if.tlast, 0);
    chk("rst_spi_addr", spi_addr, 0);
    rst = 1'b0;
    @(posedge clk); #2;

    // Single byte frame: A5 out, 3C back
    start_frame(0, 1, 0, -1, 1); wait_done();
    // Four byte frame with random gaps
    start_frame(3, 0, 0, -1, 0); wait_done();
    // Fill frame (data source depends on build)
    start_frame(2, 1, 1, -1, 0); wait_done();
    // Stray tlast on the second RX byte
    start_frame(3, 1, 0, 1, 0); wait_done();

    // Reset in the middle of a five byte frame
    start_frame(4, 1, 0, -1, 0);
    begin
      int guard = 0;
      while (tx_frame_cnt < 2 && guard < 2000) begin
        @(posedge clk); #2;
        guard++;
      end
      if (tx_frame_cnt < 2) chk("mid_frame_timeout", 1, 0);
    end
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_req_ready", req_ready, 1);
    chk("midrst_m_spi_tvalid", spi_tx_if.tvalid, 0);
    chk("midrst_spi_addr", spi_addr, 0);
    start_frame(0, 0, 0, -1, 0); wait_done();

    // Maximum length frame
    start_frame(255, 1, 0, -1, 0); wait_done();

    // Random frames
    for (int k = 0; k < 6; k++) begin
      start_frame(int'($urandom_range(0, 15)), int'($urandom_range(0, 1)),
                  bit'($urandom_range(0, 1)), -1, 0);
      wait_done();
    end

    repeat (5) @(posedge clk);
    #2;
    chk("tx_queue_empty", exp_tx.size(), 0);
    chk("rx_queue_empty", exp_rx.size(), 0);
    chk("done_total", done_cnt, exp_done_total);
    chk("err_total", err_cnt, exp_err_total);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axis_spi_frame_ctrl.md
# axis_spi_frame_ctrl

Frame sequencer placed directly upstream of the AXI-Stream SPI master. Accepts a frame request (slave address, byte count), streams that many TX bytes into the master's slave AXIS port, and marks the last one with `tlast` so chip-select releases at the frame boundary. Holds the slave address stable for the whole frame. Forwards the returned MISO bytes to a user RX stream with its own frame-accurate `tlast`.

## Interface
Parameters:
- `DATA_WIDTH`, 8: byte width on all streams.
- `SLAVE_NUM`, 2: number of chip-selects; `ADDR_W = max(1, $clog2(SLAVE_NUM))`.
- `MAX_LEN`, 256: maximum bytes per frame, power of two ≥ 2; `LEN_W = $clog2(MAX_LEN)`.
- `FILL_BYTE`, 8'hFF: MOSI byte used in fill frames.

Ports:
- `clk_i`, in, 1: the single clock.
- `rst_i`, in, 1: reset, synchronous, active-high.
- `req_valid_i`, in, 1: frame request valid.
- `req_ready_o`, out, 1: request accepted when both are high.
- `req_addr_i`, in, `ADDR_W`: target slave.
- `req_len_i`, in, `LEN_W`: frame length minus one.
- `req_fill_i`, in, 1: fill frame; TX bytes come from `FILL_BYTE`, not from `s_tx`.
- `s_tx`, `axis_if.slave`, `DATA_WIDTH`: user TX bytes. `tlast` is ignored.
- `m_spi`, `axis_if.master`, `DATA_WIDTH`: connects to the SPI master's `s_axis`.
- `spi_addr_o`, out, `ADDR_W`: connects to the master's `addr_i`.
- `s_spi`, `axis_if.slave`, `DATA_WIDTH`: connects to the master's `m_axis`.
- `m_rx`, `axis_if.master`, `DATA_WIDTH`: user RX bytes.
- `busy_o`, out, 1: a frame is in progress.
- `done_o`, out, 1: one-cycle pulse when a frame completes.
- `err_o`, out, 1: one-cycle pulse on an RX framing mismatch.

## Operation
- FSM states: `IDLE`, `RUN`, `DRAIN`.
- **IDLE**
  - `req_ready_o = 1`.
  - On request handshake: latch addr/len/fill, clear `tx_cnt` and `rx_cnt`, go to RUN.
- **RUN**
  - `m_spi.tvalid = fill ? 1 : s_tx.tvalid`.
  - `m_spi.tdata = fill ? FILL_BYTE : s_tx.tdata`.
  - `s_tx.tready = ~fill & m_spi.tready`.
  - `m_spi.tlast = (tx_cnt == len)`.
  - Each `m_spi` handshake increments `tx_cnt`.
  - A handshake with `tlast` goes to DRAIN. If the final RX byte is accepted in the same cycle, go straight to IDLE.
- **DRAIN**
  - `m_spi.tvalid = 0`, `s_tx.tready = 0`.
  - Wait for the remaining RX bytes.
- **RX path (RUN and DRAIN)**
  - Combinational pass-through: `m_rx.tdata = s_spi.tdata`, `m_rx.tvalid = s_spi.tvalid`, `s_spi.tready = m_rx.tready`.
  - `m_rx.tlast = (rx_cnt == len)`; it replaces the master's `tlast`.
  - Each `m_rx` handshake increments `rx_cnt`.
  - The handshake with `rx_cnt == len` returns the FSM to IDLE and raises `done_o` the next cycle.
- **RX path (IDLE)**
  - `s_spi.tready = 1`: stray bytes are discarded, not forwarded.
  - `m_rx.tvalid = 0`.
- `err_o` pulses when an accepted `s_spi` byte has `s_spi.tlast` differing from `(rx_cnt == len)`. The byte is still forwarded and counting continues.
- `spi_addr_o` holds the latched address from request acceptance until the FSM returns to IDLE, and keeps that value while idle.
- Counters are `LEN_W` bits, count 0..len, and never wrap. `len = MAX_LEN-1` yields `MAX_LEN` bytes.
- `busy_o = (state != IDLE)`.

## Timing
- Reset values:
  - `req_ready_o = 1`.
  - `busy_o`, `done_o`, `err_o`, `m_spi.tvalid`, `m_rx.tvalid`, `m_spi.tlast`, `m_rx.tlast` all 0.
  - `spi_addr_o = 0`, state IDLE.
- Request accepted in cycle N: `busy_o` = 1 and `m_spi.tvalid` can be first asserted in N+1.
- TX and RX data paths have zero latency (combinational).
- `done_o` is registered: high in the cycle after the final RX handshake. `busy_o` falls in that same cycle, so a new request is accepted at the earliest in that cycle.
- Valid is never dropped without a handshake, and data is stable while valid and not ready, on both master ports.
- Reset mid-frame: the block returns to IDLE in the next cycle and counters clear. The SPI master is reset by its own reset; the system must assert both resets together.

## Configuration
- `AXIS_SPI_FRAME_FILL_EN` defined:
  - `req_fill_i` behaves as above.
  - Fill frames emit `FILL_BYTE` back-to-back without consuming `s_tx`.
- `AXIS_SPI_FRAME_FILL_EN` undefined:
  - `req_fill_i` is ignored and treated as 0.
  - The fill mux is absent and every TX byte comes from `s_tx`.

## Structure
- Package `axis_spi_pkg` holds the FSM state enum `frame_state_t` (`IDLE`, `RUN`, `DRAIN`) and the `ADDR_W`/`LEN_W` derivation functions.
- One sub-module, `axis_spi_beat_cnt`: a clearable `LEN_W` beat counter with an `== len` compare output. It is instantiated twice, for TX and RX.

## Test plan
- Len 0 (1 byte), addr 1, TX 8'hA5, slave echoes 8'h3C → `m_spi` carries A5 with `tlast`, `spi_addr_o` = 1 throughout, `m_rx` carries 3C with `tlast`, `done_o` one cycle later.
- Len 3, `s_tx` with random valid gaps, `m_rx.tready` toggling → exactly 4 bytes each way, in order, `tlast` only on the 4th, no `err_o`.
- Fill frame with len 2 and macro defined → three 8'hFF bytes, `s_tx.tready` stays 0. With the macro undefined → bytes come from `s_tx`.
- Injected `s_spi.tlast` on the 2nd of 4 RX bytes → `err_o` pulses once, all 4 bytes forwarded, `m_rx.tlast` on the 4th only.
- `rst_i` asserted after 2 of 5 TX bytes → next cycle IDLE, `busy_o` 0, `req_ready_o` 1; a following len-0 frame completes correctly.
- Len 255 with `MAX_LEN` = 256 → 256 bytes each way, counters do not wrap, `done_o` once.
